intersect_engine: RTL and testbench
===================================

INTERSECT_ENGINE -- requirements
Module: intersect_engine

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the signed coordinate width in bits; radii are N+1 bits unsigned.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port g_init, input, 3N+1 bits: circle B, packed as {xB[3N:2N+1], yB[2N:N+1], rB[N:0]}.
REQ-005 The block SHALL have port e_init, input, 3N+1 bits: circle C, packed as {xC, yC, rC} with the same layout.
REQ-006 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the input handshake.
REQ-007 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the output handshake.
REQ-008 The block SHALL have ports x1D, y1D, x2D, y2D, outputs, each 3N+8 bits signed: the intersection coordinates scaled by d2.
REQ-009 The block SHALL have port d2, output, 2N+3 bits unsigned: the common denominator 2D.
REQ-010 The block SHALL have port nosol, output, 1 bit: no intersection exists, or the circles are concentric.

Function
REQ-011 The block SHALL compute the following at full precision with no overflow:
- dx = xC-xB and dy = yC-yB, each N+1 bits signed.
- D = dx²+dy².
- K = rB²-rC²+D.
- disc = 4·D·rB² - K², 4N+7 bits signed.
- S = floor(sqrt(disc)).
REQ-012 The block SHALL produce:
- x1D = 2D·xB + K·dx - S·dy
- y1D = 2D·yB + K·dy + S·dx
- x2D = 2D·xB + K·dx + S·dy
- y2D = 2D·yB + K·dy - S·dx
- d2 = 2D
REQ-013 The FSM SHALL have states IDLE, PREP, DISC, SQRT, COMB and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; on in_valid&in_ready the block SHALL capture g_init/e_init and go to PREP; in_ready SHALL be 0 in every other state.
REQ-015 PREP SHALL register dx, dy, D and K in 1 cycle; DISC SHALL register disc in 1 cycle.
REQ-016 SQRT SHALL be a restoring bit-serial square root, one result bit per cycle, for exactly 2N+3 cycles.
REQ-017 COMB SHALL register all outputs in 1 cycle and go to DONE.
REQ-018 out_valid SHALL assert exactly 2N+6 cycles after the accepting edge; latency SHALL be fixed and data-independent.
REQ-019 In DONE, out_valid SHALL be 1 and all outputs SHALL be held stable until out_valid&out_ready, then the FSM SHALL go to IDLE; no new input is accepted on that same edge.
REQ-020 If disc<0 or D==0, then nosol SHALL be 1 and x1D, y1D, x2D, y2D and d2 SHALL be 0; the SQRT step count SHALL be unchanged.
REQ-021 If disc==0, then S SHALL be 0, x1D==x2D and y1D==y2D, and nosol SHALL be 0.
REQ-022 Input values on g_init/e_init outside the accepting edge SHALL have no effect.

Reset
REQ-023 On rst=0 the block SHALL enter IDLE immediately, regardless of the current state, including mid-SQRT; the in-flight job is discarded.
REQ-024 During reset, in_ready SHALL be 0, out_valid 0, nosol 0, and x1D, y1D, x2D, y2D and d2 all 0.
REQ-025 in_ready SHALL rise on the first clk edge after rst releases.

Configuration
REQ-026 Macro INTERSECT_TANGENT_EN, when defined, SHALL add output port tangent (1 bit): 1 in DONE when disc==0 and D!=0, else 0, and 0 under reset.
REQ-027 Without INTERSECT_TANGENT_EN the tangent port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 N=8, B=(-16,-111,236), C=(109,-99,183) -> out_valid at +22 cycles, with:
- d2=31538
- x1D=3696308, y1D=2643369
- x2D=4788476, y2D=-8733381
- nosol=0
REQ-029 N=8, B=(0,0,10), C=(20,0,10) -> x1D=x2D=8000, y1D=y2D=0, d2=800, nosol=0; tangent=1 with INTERSECT_TANGENT_EN.
REQ-030 N=8, B=(0,0,10), C=(100,0,10), and separately B=C=(5,5,20) -> nosol=1, all coordinate outputs and d2 0, latency still 22.
REQ-031 The REQ-028 case with out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; one transfer on out_ready=1, then in_ready=1 next cycle.
REQ-032 rst pulsed low during the SQRT state -> out_valid=0 and in_ready=0 immediately; after release, a new REQ-028 job yields correct results at +22 cycles.

Source files
------------

// File: rtl/intersect_engine.sv
// intersect_engine
//   Finds the two intersection points of circle B and circle C. Every result
//   is scaled by the common denominator d2 = 2*D, so it stays exact in
//   integer arithmetic.
//   Fixed latency: out_valid rises 2N+6 clocks after the accepting edge.
//   The integer square root takes 2N+3 of those clocks, one root bit per clock.
//
// Ports
//   clk                 single clock, rising edge
//   rst                 asynchronous reset, active low
//   g_init / e_init     circle B / C as {x[3N:2N+1], y[2N:N+1], r[N:0]}
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   out_valid/out_ready output handshake; results are held until transfer
//   x1D,y1D,x2D,y2D     intersection points scaled by d2 (signed, 3N+8 bits)
//   d2                  2*D, where D = dx^2 + dy^2
//   nosol               no intersection, or concentric circles (results are 0)
//   tangent             only with INTERSECT_TANGENT_EN: disc==0 and D!=0,
//                       valid in DONE
//
// Configuration macro: INTERSECT_TANGENT_EN
//
// state | meaning
// IDLE  | ready for a job; in_ready high
// PREP  | dx, dy, D, K registered
// DISC  | discriminant registered, square-root engine seeded
// SQRT  | restoring square root, one result bit per clock
// COMB  | final products and sums registered into the outputs
// DONE  | out_valid high, outputs held until out_ready
module intersect_engine #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*N:0]          g_init,
  input  logic [3*N:0]          e_init,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [3*N+7:0] x1D,
  output logic signed [3*N+7:0] y1D,
  output logic signed [3*N+7:0] x2D,
  output logic signed [3*N+7:0] y2D,
  output logic [2*N+2:0]        d2,
  output logic                  nosol
`ifdef INTERSECT_TANGENT_EN
  ,
  output logic                  tangent
`endif
);

  localparam int WC = N + 1;      // dx, dy
  localparam int WD = 2 * N + 2;  // D
  localparam int WK = 2 * N + 4;  // K
  localparam int WS = 4 * N + 7;  // disc
  localparam int M  = 2 * N + 3;  // root bits
  localparam int W  = 3 * N + 8;  // outputs
  localparam int CW = $clog2(M);

  typedef enum logic [2:0] {IDLE, PREP, DISC, SQRT, COMB, DONE} state_t;

  state_t               r_state;
  logic                 r_in_ready, r_out_valid, r_nosol;
  logic signed [N-1:0]  r_xb, r_yb, r_xc, r_yc;
  logic [N:0]           r_rb, r_rc;
  logic signed [WC-1:0] r_dx, r_dy;
  logic [WD-1:0]        r_d;
  logic signed [WK-1:0] r_k;
  logic [2*M-1:0]       r_rad;
  logic [M-1:0]         r_rem, r_root;
  logic [CW-1:0]        r_cnt;
  logic                 r_ns;
  logic signed [W-1:0]  r_x1, r_y1, r_x2, r_y2;
  logic [M-1:0]         r_d2;
`ifdef INTERSECT_TANGENT_EN
  logic                 r_dz, r_tangent;
`endif

  // PREP datapath
  logic signed [WC-1:0] w_dx, w_dy;
  logic signed [WK-1:0] w_dxk, w_dyk, w_rbk, w_rck, w_dsq, w_k;
  assign w_dx  = WC'(r_xc) - WC'(r_xb);
  assign w_dy  = WC'(r_yc) - WC'(r_yb);
  assign w_dxk = WK'(w_dx);
  assign w_dyk = WK'(w_dy);
  assign w_rbk = $signed(WK'(r_rb));
  assign w_rck = $signed(WK'(r_rc));
  assign w_dsq = w_dxk * w_dxk + w_dyk * w_dyk;
  assign w_k   = w_rbk * w_rbk - w_rck * w_rck + w_dsq;

  // DISC datapath
  logic signed [WS-1:0] w_ds, w_rbs, w_ks, w_disc;
  logic                 w_nosol;
  assign w_ds    = $signed(WS'(r_d));
  assign w_rbs   = $signed(WS'(r_rb));
  assign w_ks    = WS'(r_k);
  assign w_disc  = ((w_ds * w_rbs * w_rbs) <<< 2) - w_ks * w_ks;
  assign w_nosol = w_disc[WS-1] | (r_d == '0);

  // Restoring square-root step: bring down two radicand bits and try root*4+1
  logic [M+1:0] w_rem_sh, w_trial;
  logic         w_ge;
  assign w_rem_sh = {r_rem, r_rad[2*M-1 -: 2]};
  assign w_trial  = {r_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);

  // COMB datapath
  logic signed [W-1:0] w_d2w, w_xbw, w_ybw, w_kw, w_dxw, w_dyw, w_sw;
  logic signed [W-1:0] w_bx, w_by, w_sdx, w_sdy;
  assign w_d2w = $signed(W'({r_d, 1'b0}));
  assign w_xbw = W'(r_xb);
  assign w_ybw = W'(r_yb);
  assign w_kw  = W'(r_k);
  assign w_dxw = W'(r_dx);
  assign w_dyw = W'(r_dy);
  assign w_sw  = $signed(W'(r_root));
  assign w_bx  = w_d2w * w_xbw + w_kw * w_dxw;
  assign w_by  = w_d2w * w_ybw + w_kw * w_dyw;
  assign w_sdx = w_sw * w_dxw;
  assign w_sdy = w_sw * w_dyw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_nosol     <= 1'b0;
      r_xb        <= '0;
      r_yb        <= '0;
      r_xc        <= '0;
      r_yc        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_d         <= '0;
      r_k         <= '0;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_ns        <= 1'b0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_x2        <= '0;
      r_y2        <= '0;
      r_d2        <= '0;
`ifdef INTERSECT_TANGENT_EN
      r_dz        <= 1'b0;
      r_tangent   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            {r_xb, r_yb, r_rb} <= g_init;
            {r_xc, r_yc, r_rc} <= e_init;
            r_in_ready         <= 1'b0;
            r_state            <= PREP;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        PREP: begin
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_d     <= WD'(w_dsq);
          r_k     <= w_k;
          r_state <= DISC;
        end
        DISC: begin
          r_ns    <= w_nosol;
          // A zeroed radicand keeps the same step count for the no-solution case
          r_rad   <= w_nosol ? '0 : w_disc[2*M-1:0];
          r_rem   <= '0;
          r_root  <= '0;
          r_cnt   <= CW'(M - 1);
`ifdef INTERSECT_TANGENT_EN
          r_dz    <= (w_disc == '0) && (r_d != '0);
`endif
          r_state <= SQRT;
        end
        SQRT: begin
          r_rem  <= M'(w_ge ? (w_rem_sh - w_trial) : w_rem_sh);
          r_root <= {r_root[M-2:0], w_ge};
          r_rad  <= {r_rad[2*M-3:0], 2'b00};
          if (r_cnt == '0) r_state <= COMB;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        COMB: begin
          r_nosol     <= r_ns;
          r_x1        <= r_ns ? '0 : w_bx - w_sdy;
          r_y1        <= r_ns ? '0 : w_by + w_sdx;
          r_x2        <= r_ns ? '0 : w_bx + w_sdy;
          r_y2        <= r_ns ? '0 : w_by - w_sdx;
          r_d2        <= r_ns ? '0 : {r_d, 1'b0};
`ifdef INTERSECT_TANGENT_EN
          r_tangent   <= r_dz;
`endif
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef INTERSECT_TANGENT_EN
            r_tangent   <= 1'b0;
`endif
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign nosol     = r_nosol;
  assign x1D       = r_x1;
  assign y1D       = r_y1;
  assign x2D       = r_x2;
  assign y2D       = r_y2;
  assign d2        = r_d2;
`ifdef INTERSECT_TANGENT_EN
  assign tangent   = r_tangent;
`endif

endmodule

// File: tb/tb_intersect_engine.sv
// Bench for intersect_engine (N=8). A table of circle pairs is built first:
// hand-computed constants plus model-derived random pairs. The table is then
// streamed through the block. Expected records are queued on the accepting
// edge and popped when out_valid rises.
module tb_intersect_engine;
  localparam int N   = 8;
  localparam int W   = 3 * N + 8;
  localparam int GW  = 3 * N + 1;
  localparam int RW  = N + 1;
  localparam int DW  = 2 * N + 3;
  localparam int LAT = 2 * N + 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [GW-1:0]       g_init, e_init;
  logic                in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] x1D, y1D, x2D, y2D;
  logic [DW-1:0]       d2;
  logic                nosol;
`ifdef INTERSECT_TANGENT_EN
  logic                tangent;
`endif

  always #5 clk = ~clk;

  intersect_engine #(.N(N)) dut (
    .clk(clk), .rst(rst), .g_init(g_init), .e_init(e_init),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1D(x1D), .y1D(y1D), .x2D(x2D), .y2D(y2D), .d2(d2), .nosol(nosol)
`ifdef INTERSECT_TANGENT_EN
    , .tangent(tangent)
`endif
  );

  typedef struct {
    logic signed [N-1:0] xb, yb, xc, yc;
    logic [RW-1:0]       rb, rc;
    logic signed [W-1:0] x1, y1, x2, y2;
    logic [DW-1:0]       d2;
    logic                ns, tg;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endfunction

  function automatic vec_t mk(input int xb, yb, rb, xc, yc, rc,
                              input longint x1, y1, x2, y2, dd, input int ns, tg);
    vec_t v;
    v.xb = N'(xb); v.yb = N'(yb); v.rb = RW'(rb);
    v.xc = N'(xc); v.yc = N'(yc); v.rc = RW'(rc);
    v.x1 = W'(x1); v.y1 = W'(y1); v.x2 = W'(x2); v.y2 = W'(y2);
    v.d2 = DW'(dd); v.ns = ns[0]; v.tg = tg[0];
    return v;
  endfunction

  // Reference: 64-bit arithmetic with a binary-search integer square root
  function automatic vec_t model(input int xb, yb, rb, xc, yc, rc);
    longint dx, dy, dd, k, disc, s, lo, hi, mid;
    int     ns, tg;
    dx   = longint'(xc - xb);
    dy   = longint'(yc - yb);
    dd   = dx * dx + dy * dy;
    k    = longint'(rb) * rb - longint'(rc) * rc + dd;
    disc = 4 * dd * rb * rb - k * k;
    ns   = (disc < 0 || dd == 0) ? 1 : 0;
    tg   = (disc == 0 && dd != 0) ? 1 : 0;
    s    = 0;
    if (disc > 0) begin
      lo = 0; hi = 64'sd1 << 21;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mid * mid <= disc) lo = mid; else hi = mid;
      end
      s = lo;
    end
    if (ns != 0)
      return mk(xb, yb, rb, xc, yc, rc, 0, 0, 0, 0, 0, 1, tg);
    return mk(xb, yb, rb, xc, yc, rc,
              2 * dd * xb + k * dx - s * dy, 2 * dd * yb + k * dy + s * dx,
              2 * dd * xb + k * dx + s * dy, 2 * dd * yb + k * dy - s * dx,
              2 * dd, 0, tg);
  endfunction

  task automatic cmp_out(input vec_t e, input string tag);
    chk({tag, ".x1D"}, x1D, e.x1);
    chk({tag, ".y1D"}, y1D, e.y1);
    chk({tag, ".x2D"}, x2D, e.x2);
    chk({tag, ".y2D"}, y2D, e.y2);
    chk({tag, ".d2"}, d2, e.d2);
    chk({tag, ".nosol"}, nosol, e.ns);
`ifdef INTERSECT_TANGENT_EN
    chk({tag, ".tangent"}, tangent, e.tg);
`endif
  endtask

  task automatic run_job(input vec_t v, input int hold, input string tag);
    int   cyc, busy_err;
    vec_t e;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk({tag, ".ready_wait"}, in_ready, 1);
    g_init   = {v.xb, v.yb, v.rb};
    e_init   = {v.xc, v.yc, v.rc};
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 1'b0;
    cyc = 0; busy_err = 0;
    do begin
      g_init = GW'($urandom);
      e_init = GW'($urandom);
      @(posedge clk); #1; cyc++;
      if (in_ready) busy_err++;
    end while (!out_valid && cyc < LAT + 10);
    chk({tag, ".latency"}, cyc, LAT);
    chk({tag, ".busy_ready"}, busy_err, 0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    cmp_out(e, tag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_ready"}, in_ready, 0);
      cmp_out(e, {tag, ".hold"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_ready"}, in_ready, 1);
  endtask

  initial begin
    int xb, yb, xc, yc, rb, rc;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    g_init = '0; e_init = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.nosol", nosol, 0);
    chk("rst.d2", d2, 0);
    chk("rst.x1D", x1D, 0);
`ifdef INTERSECT_TANGENT_EN
    chk("rst.tangent", tangent, 0);
`endif
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rel.in_ready", in_ready, 1);

    tbl.push_back(mk(-16, -111, 236, 109, -99, 183,
                     3696308, 2643369, 4788476, -8733381, 31538, 0, 0));
    tbl.push_back(mk(0, 0, 10, 20, 0, 10, 8000, 0, 8000, 0, 800, 0, 1));
    tbl.push_back(mk(0, 0, 10, 100, 0, 10, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(5, 5, 20, 5, 5, 20, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 5, 6, 0, 5, 216, 288, 216, -288, 72, 0, 0));
    tbl.push_back(model(0, 0, 0, 3, 4, 5));
    tbl.push_back(model(-128, -128, 511, 127, 127, 511));
    tbl.push_back(model(127, -128, 300, -128, 127, 200));
    for (int i = 0; i < 12; i++) begin
      xb = int'($urandom_range(255)) - 128;
      yb = int'($urandom_range(255)) - 128;
      xc = int'($urandom_range(255)) - 128;
      yc = int'($urandom_range(255)) - 128;
      rb = int'($urandom_range(511));
      rc = int'($urandom_range(511));
      tbl.push_back(model(xb, yb, rb, xc, yc, rc));
    end

    foreach (tbl[i]) run_job(tbl[i], (i == 0) ? 5 : 0, $sformatf("vec%0d", i));

    // Reset in the middle of SQRT
    run_job(tbl[0], 0, "pre_rst");
    g_init   = {tbl[0].xb, tbl[0].yb, tbl[0].rb};
    e_init   = {tbl[0].xc, tbl[0].yc, tbl[0].rc};
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(tbl[0]);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 0);
    chk("midrst.d2", d2, 0);
    chk("midrst.x1D", x1D, 0);
    chk("midrst.nosol", nosol, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.rel_ready", in_ready, 1);
    run_job(tbl[0], 0, "post_rst");
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
